// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM user-side clients: address field widths,
// read-streamer FSM encoding and the segment length helper.
package sdram_pkg;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int LEN_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_STREAM  = 3'd2,
    ST_SEG_END = 3'd3,
    ST_FLUSH   = 3'd4
  } rd_state_e;

  // Smaller of two word counts; used to clip a segment to the words left.
  function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    if (a < b) begin
      min_len = a;
    end else begin
      min_len = b;
    end
  endfunction

endpackage

// File: rtl/sdram_skid2.sv
// Two-entry valid/ready skid buffer with bypass: when empty, an incoming word
// is presented downstream in the same cycle and only stored if not accepted.
// The producer must never push while the buffer holds two words.
module sdram_skid2 #(
  parameter int W = 17
) (
  input  logic         clk_rw,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         wr_ptr_s;
  logic         store_s;
  logic         pop_buf_s;

  // Front of buffer if occupied, otherwise pass the incoming word through
  always_comb begin
    out_valid = 1'b0;
    out_data  = {W{1'b0}};
    if (count_r != 2'd0) begin
      out_valid = 1'b1;
      out_data  = mem_r[rd_ptr_r];
    end else if (in_valid) begin
      out_valid = 1'b1;
      out_data  = in_data;
    end else begin
      out_valid = 1'b0;
      out_data  = {W{1'b0}};
    end
  end

  // Store unless the word bypasses straight out; pop only stored words
  always_comb begin
    wr_ptr_s  = rd_ptr_r ^ count_r[0];
    pop_buf_s = out_ready && (count_r != 2'd0);
    if (in_valid && !((count_r == 2'd0) && out_ready)) begin
      store_s = 1'b1;
    end else begin
      store_s = 1'b0;
    end
  end

  // Storage, read pointer and occupancy
  always_ff @(posedge clk_rw or posedge rst) begin
    if (rst) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (store_s) begin
        mem_r[wr_ptr_s] <= in_data;
      end
      if (pop_buf_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, store_s} - {1'b0, pop_buf_s};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/sdram_rd_streamer.sv
// Read-side client of sdram_mcb: splits one read job into rd_load segments,
// drains the MCB read FIFO and presents the words as a valid/ready stream
// with last-word marking.
// Optional MCB protocol checking on err: define SDRAM_RD_STREAMER_CHK_EN.
module sdram_rd_streamer
  import sdram_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int SEG_LEN = 256
) (
  input  logic              clk_rw,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [23:0]       total_len,
  output logic              busy,
  output logic              done,
  output logic              rd_load,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_length,
  output logic              rd_req,
  input  logic [DATA_W-1:0] mcb_dout,
  input  logic              rd_fifo_empty,
  input  logic              rd_done,
  input  logic              rd_underrun,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              err
);

  localparam logic [23:0] SEG_LEN_L = 24'(SEG_LEN);

  rd_state_e         state_r, state_s;
  logic [ADDR_W-1:0] seg_addr_r, seg_addr_s;
  logic [23:0]       remain_r, remain_s;
  logic [23:0]       seg_len_r, seg_len_s;
  logic [23:0]       pull_cnt_r, pull_cnt_s;
  logic              rd_done_seen_r, rd_done_seen_s;
  logic              inflight_r;
  logic              inflight_last_r;
  logic              rd_req_s;
  logic              last_pull_s;
  logic              done_s;
  logic [1:0]        skid_cnt_s;
  logic              skid_valid_s;
  logic [DATA_W:0]   skid_out_s;

  // Next-state, segment bookkeeping and FIFO pop decision
  always_comb begin
    state_s        = state_r;
    seg_addr_s     = seg_addr_r;
    remain_s       = remain_r;
    seg_len_s      = seg_len_r;
    pull_cnt_s     = pull_cnt_r;
    rd_done_seen_s = rd_done_seen_r;
    rd_req_s       = 1'b0;
    done_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (total_len != 24'd0)) begin
          seg_addr_s = base_addr;
          remain_s   = total_len;
          seg_len_s  = min_len(SEG_LEN_L, total_len);
          state_s    = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pull_cnt_s     = 24'd0;
        rd_done_seen_s = 1'b0;
        state_s        = ST_STREAM;
      end
      ST_STREAM: begin
        // The word requested now lands one cycle later; never let it overflow
        if (!rd_fifo_empty && (pull_cnt_r < seg_len_r) &&
            (({1'b0, skid_cnt_s} + {2'b00, inflight_r}) < 3'd2)) begin
          rd_req_s   = 1'b1;
          pull_cnt_s = pull_cnt_r + 24'd1;
        end else begin
          rd_req_s   = 1'b0;
          pull_cnt_s = pull_cnt_r;
        end
        // rd_done may precede or follow the last pull, so remember it
        if (rd_done) begin
          rd_done_seen_s = 1'b1;
        end else begin
          rd_done_seen_s = rd_done_seen_r;
        end
        if ((pull_cnt_r == seg_len_r) && (rd_done_seen_r || rd_done)) begin
          state_s = ST_SEG_END;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_SEG_END: begin
        seg_addr_s = seg_addr_r + ADDR_W'(seg_len_r);
        remain_s   = remain_r - seg_len_r;
        if (remain_r > seg_len_r) begin
          seg_len_s = min_len(SEG_LEN_L, remain_r - seg_len_r);
          state_s   = ST_LOAD;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!skid_valid_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // The final pull of the final segment carries the job's last word
  always_comb begin
    if ((remain_r == seg_len_r) && (pull_cnt_r == (seg_len_r - 24'd1))) begin
      last_pull_s = 1'b1;
    end else begin
      last_pull_s = 1'b0;
    end
  end

  // State and segment registers; reset aborts any job in progress
  always_ff @(posedge clk_rw or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      seg_addr_r      <= {ADDR_W{1'b0}};
      remain_r        <= 24'd0;
      seg_len_r       <= 24'd0;
      pull_cnt_r      <= 24'd0;
      rd_done_seen_r  <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      state_r         <= state_s;
      seg_addr_r      <= seg_addr_s;
      remain_r        <= remain_s;
      seg_len_r       <= seg_len_s;
      pull_cnt_r      <= pull_cnt_s;
      rd_done_seen_r  <= rd_done_seen_s;
      inflight_r      <= rd_req_s;
      inflight_last_r <= rd_req_s && last_pull_s;
    end
  end

  sdram_skid2 #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk_rw    (clk_rw),
    .rst       (rst),
    .in_valid  (inflight_r),
    .in_data   ({inflight_last_r, mcb_dout}),
    .out_valid (skid_valid_s),
    .out_data  (skid_out_s),
    .out_ready (m_ready),
    .count     (skid_cnt_s)
  );

  assign busy      = (state_r != ST_IDLE);
  assign done      = done_s;
  assign rd_load   = (state_r == ST_LOAD);
  assign rd_addr   = seg_addr_r;
  assign rd_length = seg_len_r;
  assign rd_req    = rd_req_s;
  assign m_valid   = skid_valid_s;
  assign m_data    = skid_out_s[DATA_W-1:0];
  assign m_last    = skid_out_s[DATA_W];

`ifdef SDRAM_RD_STREAMER_CHK_EN
  logic err_r;
  logic err_set_s;

  // MCB protocol violations: underrun mid-job, stray or repeated rd_done
  always_comb begin
    err_set_s = 1'b0;
    if (rd_underrun && busy) begin
      err_set_s = 1'b1;
    end else if (rd_done && (state_r != ST_STREAM)) begin
      err_set_s = 1'b1;
    end else if (rd_done && rd_done_seen_r) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_rw or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  assign err = err_r;
`else
  logic chk_unused_s;
  assign chk_unused_s = rd_underrun;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_rd_streamer.sv
// Self-checking bench for sdram_rd_streamer with a behavioural MCB model,
// a job-level expected-word queue and randomized ready/FIFO-gap stimulus.
`timescale 1ns/1ps
module tb_sdram_rd_streamer;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int SEG_LEN = 256;

  logic              clk_rw = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = 24'd0;
  logic [23:0]       total_len = 24'd0;
  logic              busy, done, rd_load, rd_req, m_valid, m_last, err;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_length;
  logic [DATA_W-1:0] mcb_dout = 16'd0;
  logic [DATA_W-1:0] m_data;
  logic              rd_fifo_empty = 1'b1;
  logic              rd_done = 1'b0;
  logic              rd_underrun = 1'b0;
  logic              m_ready = 1'b0;

  always #5 clk_rw = ~clk_rw;

  sdram_rd_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEG_LEN(SEG_LEN)) dut (
    .clk_rw(clk_rw), .rst(rst), .start(start), .base_addr(base_addr),
    .total_len(total_len), .busy(busy), .done(done), .rd_load(rd_load),
    .rd_addr(rd_addr), .rd_length(rd_length), .rd_req(rd_req),
    .mcb_dout(mcb_dout), .rd_fifo_empty(rd_fifo_empty), .rd_done(rd_done),
    .rd_underrun(rd_underrun), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory content the MCB model returns for a given word address.
  function automatic logic [15:0] word_at(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5a3c;
  endfunction

  // ---------------- model state ----------------
  bit          job_active = 1'b0;
  bit          load_due = 1'b0;
  logic [16:0] exp_q[$];
  logic [47:0] load_q[$];
  logic [15:0] mcb_q[$];
  logic [23:0] obs_addr[$];
  logic [23:0] obs_len[$];
  logic [23:0] prod_addr = 24'd0;
  int          prod_left = 0;
  int          done_timer = -1;
  bit          pop_pend = 1'b0;
  logic [15:0] pop_data = 16'd0;
  int          stored = 0;
  int          words_out = 0;
  int          done_cnt = 0;
  bit          err_exp = 1'b0;
  int          rdy_mode = 0;
  bit          gap_en = 1'b0;
  bit          inj_underrun = 1'b0;
  int          cyc = 0;

  // Input drivers for the MCB side and downstream ready
  always @(posedge clk_rw) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    rd_fifo_empty = (mcb_q.size() == 0) || (gap_en && ($urandom_range(0, 3) == 0));
    mcb_dout      = pop_pend ? pop_data : 16'($urandom);
    rd_done       = (done_timer == 0);
    rd_underrun   = inj_underrun;
  end

  // Compare process: outputs against the job-level model every cycle
  always @(negedge clk_rw) begin
    bit          cur_valid;
    bit          hs;
    logic [16:0] e;
    if (rst) begin
      check("reset_out_a", {busy, done, rd_load, rd_req, m_valid, m_last, err, m_data}, 64'd0);
      check("reset_out_b", {rd_addr, rd_length}, 64'd0);
      job_active = 1'b0; load_due = 1'b0;
      exp_q.delete(); load_q.delete(); mcb_q.delete();
      prod_left = 0; done_timer = -1; pop_pend = 1'b0; stored = 0; err_exp = 1'b0;
    end else begin
      cur_valid = pop_pend;
      check("busy", busy, job_active);
      check("err", err, err_exp);
      check("m_valid", m_valid, (stored > 0) || cur_valid);
      if (stored == 2) check("rd_req_when_full", rd_req, 1'b0);
      if (load_due) check("start_to_load", rd_load, 1'b1);
      load_due = 1'b0;
      if (rd_load) begin
        if (load_q.size() == 0) check("unexpected_load", 1'b1, 1'b0);
        else check("load_addr_len", {rd_addr, rd_length}, load_q.pop_front());
        obs_addr.push_back(rd_addr);
        obs_len.push_back(rd_length);
        prod_addr = rd_addr;
        prod_left = int'(rd_length);
      end
      if (rd_req) begin
        check("rd_req_when_empty", rd_fifo_empty, 1'b0);
        if (mcb_q.size() > 0) pop_data = mcb_q.pop_front();
      end
      pop_pend = rd_req && !rd_fifo_empty;
      hs = m_valid && m_ready;
      if (hs) begin
        if (exp_q.size() == 0) check("extra_word", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[15:0]);
          check("m_last", m_last, e[16]);
        end
        words_out++;
      end
      stored = stored + int'(cur_valid) - int'(hs);
      if (stored > 2 || stored < 0) check("skid_depth", 1'b1, 1'b0);
`ifdef SDRAM_RD_STREAMER_CHK_EN
      if (rd_underrun && busy) err_exp = 1'b1;
`endif
      // MCB fills its FIFO one word per cycle, then signals rd_done later
      if (prod_left > 0) begin
        mcb_q.push_back(word_at(prod_addr));
        prod_addr = prod_addr + 24'd1;
        prod_left--;
        if (prod_left == 0) done_timer = int'($urandom_range(0, 12));
      end else if (done_timer == 0) done_timer = -1;
      else if (done_timer > 0) done_timer--;
      if (start && !job_active && (total_len != 24'd0)) begin
        logic [23:0] rem, a, l;
        job_active = 1'b1;
        load_due = 1'b1;
        obs_addr.delete(); obs_len.delete(); words_out = 0;
        for (int i = 0; i < int'(total_len); i++)
          exp_q.push_back({(i == int'(total_len) - 1), word_at(base_addr + 24'(i))});
        rem = total_len; a = base_addr;
        while (rem != 24'd0) begin
          l = (rem < 24'(SEG_LEN)) ? rem : 24'(SEG_LEN);
          load_q.push_back({a, l});
          a = a + l; rem = rem - l;
        end
      end
      if (done) begin
        check("done_while_active", job_active, 1'b1);
        check("done_all_words", exp_q.size(), 0);
        check("done_all_loads", load_q.size(), 0);
        job_active = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_rw); #1 rst = 1'b1;
    repeat (2) @(posedge clk_rw);
    #1 rst = 1'b0;
  endtask

  task automatic run_job(input logic [23:0] b, input logic [23:0] l, input int mode,
                         input bit gap, input bit mid_start, input bit underrun);
    int budget;
    rdy_mode = mode; gap_en = gap; done_cnt = 0;
    budget = int'(l) * 6 + 400;
    @(posedge clk_rw); #1;
    base_addr = b; total_len = l; start = 1'b1;
    @(posedge clk_rw); #2;
    start = 1'b0; base_addr = 24'($urandom); total_len = 24'($urandom);
    for (int c = 0; c < budget; c++) begin
      if (!job_active) break;
      @(posedge clk_rw); #2;
      start        = mid_start && (c == 40);
      inj_underrun = underrun && (c == 20);
    end
    start = 1'b0; inj_underrun = 1'b0;
    if (job_active) begin
      check("job_timeout", 1'b1, 1'b0);
      do_reset();
    end else if (l != 24'd0) begin
      check("one_done_pulse", done_cnt, 1);
      check("word_count", words_out, int'(l));
    end
  endtask

  initial begin
    logic [23:0] exp_a [4];
    exp_a = '{24'h1f0, 24'h2f0, 24'h3f0, 24'h4f0};
    repeat (3) @(posedge clk_rw);
    #1 rst = 1'b0;

    // Four full segments from 0x1f0
    run_job(24'h1f0, 24'd1024, 0, 1'b0, 1'b0, 1'b0);
    check("lit_nloads_1024", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      check("lit_addr_1024", obs_addr[i], exp_a[i]);
      check("lit_len_1024", obs_len[i], 24'd256);
    end

    // 19 segments, short tail
    run_job(24'($urandom), 24'h1234, 0, 1'b1, 1'b0, 1'b0);
    check("lit_nloads_1234", obs_len.size(), 19);
    if (obs_len.size() == 19) check("lit_tail_len", obs_len[18], 24'h34);
    check("lit_words_1234", words_out, 24'h1234);

    // Address wrap
    run_job(24'hffff80, 24'd512, 2, 1'b1, 1'b0, 1'b0);
    check("lit_nloads_wrap", obs_addr.size(), 2);
    if (obs_addr.size() == 2) check("lit_wrap_addr", obs_addr[1], 24'h000080);

    // Zero-length start is ignored
    run_job(24'h000100, 24'd0, 0, 1'b0, 1'b0, 1'b0);
    check("zero_len_idle", busy, 1'b0);

    // Backpressure pattern 1,0,0,1 with FIFO gaps, assorted lengths, stray start
    run_job(24'($urandom), 24'd700, 1, 1'b1, 1'b1, 1'b0);
    run_job(24'($urandom), 24'd1, 1, 1'b1, 1'b0, 1'b0);
    run_job(24'($urandom), 24'd256, 1, 1'b1, 1'b0, 1'b0);
    run_job(24'($urandom), 24'd257, 2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_job(24'($urandom), 24'($urandom_range(1, 600)), k % 3, 1'b1, 1'b0, 1'b0);

    // Underrun while busy: err sticky (CHK build) or constant 0
    run_job(24'($urandom), 24'd300, 0, 1'b1, 1'b0, 1'b1);
    repeat (5) @(posedge clk_rw);
`ifdef SDRAM_RD_STREAMER_CHK_EN
    #2 check("err_sticky", err, 1'b1);
`else
    #2 check("err_tied_low", err, 1'b0);
`endif

    // Reset in the middle of streaming, then a fresh job
    rdy_mode = 2; gap_en = 1'b1;
    @(posedge clk_rw); #1;
    base_addr = 24'h123456; total_len = 24'd700; start = 1'b1;
    @(posedge clk_rw); #1 start = 1'b0;
    repeat (60) @(posedge clk_rw);
    #1 rst = 1'b1;
    #1 check("abort_busy", busy, 1'b0);
    check("abort_req", {rd_req, rd_load, m_valid}, 3'b000);
    repeat (2) @(posedge clk_rw);
    #1 rst = 1'b0;
    run_job(24'h00abc0, 24'd600, 1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_rd_streamer.md
# sdram_rd_streamer

Read-side client of `sdram_mcb`, on the `clk_rw` user clock. Takes a single read job (base address, total word count) and splits it into fixed-size `rd_load` segments. Drains the MCB read FIFO with `rd_req`, observing its one-cycle `dout` latency. Presents the words downstream as a valid/ready stream with last-word marking, so streaming consumers never touch the MCB read handshake directly.

## Interface
- `ADDR_W`, 24, SDRAM word address width `{bank[1:0], row[12:0], col[8:0]}`.
- `DATA_W`, 16, data word width.
- `SEG_LEN`, 256, maximum words per `rd_load` command; power of two, 1..512.
- `clk_rw` in 1: user-side clock, same clock as `sdram_mcb.clk_rw`.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `base_addr` in ADDR_W: job start address, sampled with `start`.
- `total_len` in 24: job word count, actual count, not 0's based; 0 means no job (ignored).
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last word is accepted downstream.
- `rd_load` out 1: segment command pulse to the MCB.
- `rd_addr` out ADDR_W: segment address, valid with `rd_load`.
- `rd_length` out 24: segment word count, valid with `rd_load`.
- `rd_req` out 1: MCB read FIFO pop.
- `mcb_dout` in DATA_W: MCB `dout`, valid the cycle after `rd_req`.
- `rd_fifo_empty` in 1: MCB read FIFO empty.
- `rd_done` in 1: MCB segment-complete pulse.
- `rd_underrun` in 1: MCB underrun flag.
- `m_valid`, `m_data`, `m_last` out 1/DATA_W/1: downstream stream.
- `m_ready` in 1: downstream accept.
- `err` out 1: sticky error; see Configuration.

## Operation
- FSM states: IDLE, LOAD, STREAM, SEG_END, FLUSH.
- IDLE, with `start` and `total_len != 0`: latch address and length, go to LOAD. `start` outside IDLE is ignored.
- LOAD: pulse `rd_load` for exactly one cycle.
  - `rd_length` = min(`SEG_LEN`, remaining words).
  - `rd_addr` = current segment address.
  - Go to STREAM.
- STREAM: assert `rd_req` when all of the following hold:
  - `!rd_fifo_empty`;
  - the segment pull count is below `rd_length`;
  - `skid_count + inflight < 2`. `inflight` = `rd_req` issued last cycle.
- Each `mcb_dout` is written into the 2-entry skid buffer the cycle after `rd_req`.
- Segment end:
  - When all segment words are pulled **and** `rd_done` has been seen, go to SEG_END.
  - `rd_done` is latched, because it may arrive before or after the last pull.
- SEG_END:
  - Advance address by the segment length, modulo 2^ADDR_W, so addresses wrap.
  - Subtract the segment length from the remaining count.
  - Remaining > 0 → LOAD; otherwise → FLUSH.
- FLUSH: wait until the skid buffer is empty, pulse `done`, go to IDLE.
- `m_last` is high with the job's final word only.

## Timing
- Reset value of every output is 0 (`busy`, `done`, `rd_load`, `rd_addr`, `rd_length`, `rd_req`, `m_valid`, `m_data`, `m_last`, `err`). The FSM resets to IDLE and the skid buffer to empty.
- `start` → `rd_load`: 1 cycle (IDLE → LOAD).
- `rd_req` → word visible on `m_data`: 1 cycle if the skid buffer is empty.
- Zero-bubble throughput: with `m_ready` held high and the FIFO non-empty, one word per cycle.
- `rd_req` is never asserted when it could overflow the skid buffer. No word is dropped or duplicated under any `m_ready` pattern.
- Between segments there are 2 cycles without `rd_req` (SEG_END, LOAD).
- `rst` mid-job aborts immediately. No further `rd_load` or `rd_req` is issued, and the skid buffer contents are discarded.

## Configuration
- `SDRAM_RD_STREAMER_CHK_EN`, defined: `err` is set (sticky until `rst`) on any of:
  - `rd_underrun` high while `busy`;
  - `rd_done` arriving outside STREAM;
  - a second `rd_done` in the same segment.
- `SDRAM_RD_STREAMER_CHK_EN`, undefined: the port `err` still exists, tied to 0, and no check logic is built.

## Structure
- Shared package `sdram_pkg`: address field widths, FSM state encoding, and the `min` length helper.
- One sub-module, `sdram_skid2`: the 2-entry valid/ready skid buffer with occupancy count.

## Test plan
- `base_addr`=0x1f0, `total_len`=1024, `SEG_LEN`=256 → 4 `rd_load` pulses at 0x1f0/0x2f0/0x3f0/0x4f0, each length 256. Data matches the MCB model; `m_last` on word 1023; one `done` pulse.
- `total_len`=0x1234 → 19 segments, the last with `rd_length`=0x34. Exactly 0x1234 words out.
- `m_ready` pattern 1,0,0,1 repeating plus random `rd_fifo_empty` gaps → in-order, lossless data. Skid count never exceeds 2. `rd_req` is low whenever the count is 2.
- `base_addr`=0xFFFF80, `total_len`=512 → second `rd_load` at 0x000080 (wrap).
- `start` pulsed mid-job → ignored. `rst` asserted mid-STREAM → all outputs 0 next edge. A new job afterwards completes correctly.
- CHK_EN build: inject `rd_underrun` while busy → `err`=1 and stays 1 until `rst`. Non-CHK build: `err` is always 0.
